// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the one-hot responder state
// encoding, reusable by bus units on either side of the interface.
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [2:0] WB_ST_IDLE = 3'b001;
  localparam logic [2:0] WB_ST_WAIT = 3'b010;
  localparam logic [2:0] WB_ST_RESP = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = WB_ST_IDLE,
    ST_WAIT = WB_ST_WAIT,
    ST_RESP = WB_ST_RESP
  } wb_state_e;

endpackage

// File: rtl/wb_ram_sp.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port that only updates on an enabled read.
module wb_ram_sp
  import wb_pkg::*;
#(
  parameter int DEPTH  = 768,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [WB_SEL_W-1:0] sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WB_DAT_W-1:0] din,
  output logic [WB_DAT_W-1:0] dout
);

  logic [WB_DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
          if (sel[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone B4 classic responder in front of a byte-enabled RAM, with a
// programmable number of wait states. Define WB_SLAVE_RAM_ERR_EN to answer
// out-of-range addresses with ERR instead of aliasing them modulo DEPTH.
module wb_slave_ram
  import wb_pkg::*;
#(
  parameter int DEPTH       = 768,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [WB_DAT_W-1:0] wbs_dat_i,
  input  logic [WB_SEL_W-1:0] wbs_sel_i,
  output logic [WB_DAT_W-1:0] wbs_dat_o,
  output logic                wbs_ack_o,
  output logic                wbs_err_o
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  wb_state_e           state_q, state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic                ack_q, rd_q;
  logic [WB_DAT_W-1:0] hold_q;
  logic                req, go_resp, addr_bad;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_adr, ram_adr;
  logic [WB_DAT_W-1:0] cur_dat, ram_dout;
  logic [WB_SEL_W-1:0] cur_sel;

  assign req = wbs_cyc_i & wbs_stb_i;

  // With zero wait states the RAM access happens on the request edge itself,
  // so the live bus inputs feed the RAM; otherwise the latched copies do.
  assign cur_we  = (state_q == ST_IDLE) ? wbs_we_i  : we_q;
  assign cur_adr = (state_q == ST_IDLE) ? wbs_adr_i : adr_q;
  assign cur_dat = (state_q == ST_IDLE) ? wbs_dat_i : dat_q;
  assign cur_sel = (state_q == ST_IDLE) ? wbs_sel_i : sel_q;

`ifdef WB_SLAVE_RAM_ERR_EN
  logic err_q;

  assign addr_bad  = int'(cur_adr) >= DEPTH;
  assign ram_adr   = cur_adr;
  assign wbs_err_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= go_resp & addr_bad;
  end
`else
  function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % 32'(DEPTH));
  endfunction

  assign addr_bad  = 1'b0;
  assign ram_adr   = fold(cur_adr);
  assign wbs_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          go_resp = (WAIT_CYCLES == 0);
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        cnt_q <= WAIT_LD;
        we_q  <= wbs_we_i;
        adr_q <= wbs_adr_i;
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Read data comes straight from the RAM register during the ack cycle and
  // is captured afterwards so the bus sees it held until the next read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      rd_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      ack_q <= go_resp & ~addr_bad;
      rd_q  <= go_resp & ~addr_bad & ~cur_we;
      if (rd_q) hold_q <= ram_dout;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_q ? ram_dout : hold_q;

  wb_ram_sp #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk (clk_i),
    .en  (go_resp & ~addr_bad),
    .we  (cur_we),
    .sel (cur_sel),
    .addr(ram_adr),
    .din (cur_dat),
    .dout(ram_dout)
  );

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: four instances with 0/3/4/5 wait states
// share one bus, with cyc/stb steered to the instance under test.
module tb_wb_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [9:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  int          dsel;
  logic [3:0]  ack_v, err_v;
  logic [31:0] dat_v [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_slave_ram #(
      .DEPTH      (768),
      .ADDR_W     (10),
      .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 4 : 5)
    ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wbs_cyc_i(cyc && (dsel == g)),
      .wbs_stb_i(stb && (dsel == g)),
      .wbs_we_i (we),
      .wbs_adr_i(adr),
      .wbs_dat_i(dat),
      .wbs_sel_i(sel),
      .wbs_dat_o(dat_v[g]),
      .wbs_ack_o(ack_v[g]),
      .wbs_err_o(err_v[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic w, input logic [9:0] a,
                               input logic [31:0] wd, input logic [3:0] s);
    dsel = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = wd; sel = s;
  endtask

  task automatic idleBus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
  endtask

  // Runs one transfer, returns cycles to termination and the termination kind.
  task automatic transfer(input int d, input logic w, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] s, input string tag,
                          output int lat, output logic got_err, output logic [31:0] rdata);
    applyStimulus(d, w, a, wd, s);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(ack_v[d] | err_v[d]) && lat < 40);
    got_err = err_v[d];
    rdata   = dat_v[d];
    checkOutput({tag, " ack+err"}, 32'(ack_v[d] & err_v[d]), 32'd0);
    idleBus();
    tick();
    checkOutput({tag, " one-cycle"}, 32'({ack_v[d], err_v[d]}), 32'd0);
  endtask

  task automatic doWrite(input int d, input logic [9:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input int exp_lat, input string tag);
    int lat; logic e; logic [31:0] r;
    transfer(d, 1'b1, a, wd, s, tag, lat, e, r);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " err"}, 32'(e), 32'd0);
  endtask

  task automatic doRead(input int d, input logic [9:0] a, input int exp_lat,
                        input logic [31:0] exp_dat, input string tag);
    int lat; logic e; logic [31:0] r;
    transfer(d, 1'b0, a, '0, 4'h0, tag, lat, e, r);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " err"}, 32'(e), 32'd0);
    checkOutput({tag, " data"}, r, exp_dat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat, cnt;
    logic        e;
    logic [31:0] r;
    logic [8:0]  pat;

    dsel = 0;
    idleBus();
    rst = 1'b1;
    tick();
    checkOutput("reset ack", 32'(ack_v[0]), 32'd0);
    checkOutput("reset err", 32'(err_v[0]), 32'd0);
    checkOutput("reset dat", dat_v[0], 32'd0);
    #2 rst = 1'b0;
    tick();

    // Zero wait states: basic write then read.
    doWrite(0, 10'd5, 32'hDEADBEEF, 4'hF, 1, "w0 wr5");
    doRead (0, 10'd5, 1, 32'hDEADBEEF, "w0 rd5");

    // Byte enables and an all-disabled write.
    doWrite(0, 10'd9, 32'h11223344, 4'hF, 1, "be preload");
    doWrite(0, 10'd9, 32'hAABBCCDD, 4'b0101, 1, "be partial");
    doRead (0, 10'd9, 1, 32'h11BB33DD, "be rd");
    doWrite(0, 10'd9, 32'hFFFFFFFF, 4'b0000, 1, "be sel0");
    doRead (0, 10'd9, 1, 32'h11BB33DD, "be sel0 rd");
    checkOutput("dat hold", dat_v[0], 32'h11BB33DD);

    // Three wait states with the strobe held: ack every fifth cycle.
    doWrite(1, 10'd5, 32'h0BADCAFE, 4'hF, 4, "w3 wr5");
    applyStimulus(1, 1'b0, 10'd5, '0, 4'h0);
    pat = '0;
    r   = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      pat[i] = ack_v[1];
      if (i == 3) r = dat_v[1];
    end
    checkOutput("w3 ack pattern", 32'(pat), 32'(9'b100001000));
    checkOutput("w3 rd data", r, 32'h0BADCAFE);
    idleBus();
    tick();

    // Four wait states: abort and latched request fields.
    doWrite(2, 10'd7, 32'h12345678, 4'hF, 5, "w4 wr7");
    applyStimulus(2, 1'b1, 10'd7, 32'h00000001, 4'hF);
    tick();
    tick();
    idleBus();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_v[2] | err_v[2]) cnt++;
    end
    checkOutput("abort no resp", 32'(cnt), 32'd0);
    doRead(2, 10'd7, 5, 32'h12345678, "abort rd7");

    applyStimulus(2, 1'b1, 10'd8, 32'hA5A5A5A5, 4'hF);
    tick();
    we = 1'b0; adr = 10'd11; dat = '0; sel = 4'h0;
    lat = 1;
    while (!(ack_v[2] | err_v[2]) && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("latch wr latency", 32'(lat), 32'd5);
    idleBus();
    tick();
    doRead(2, 10'd8, 5, 32'hA5A5A5A5, "latch rd8");

    // Out-of-range addresses (800 aliases to 32 when errors are disabled).
    doWrite(0, 10'd32, 32'h0C0FFEE0, 4'hF, 1, "oor preload");
    doRead (0, 10'd9, 1, 32'h11BB33DD, "oor prime");
`ifdef WB_SLAVE_RAM_ERR_EN
    transfer(0, 1'b0, 10'd800, '0, 4'h0, "err rd", lat, e, r);
    checkOutput("err rd latency", 32'(lat), 32'd1);
    checkOutput("err rd flag", 32'(e), 32'd1);
    checkOutput("err rd dat", r, 32'h11BB33DD);
    transfer(0, 1'b1, 10'd800, 32'h00000BAD, 4'hF, "err wr", lat, e, r);
    checkOutput("err wr flag", 32'(e), 32'd1);
    doRead(0, 10'd32, 1, 32'h0C0FFEE0, "err ram intact");
`else
    doWrite(0, 10'd800, 32'h5A5A5A5A, 4'hF, 1, "alias wr");
    doRead (0, 10'd32, 1, 32'h5A5A5A5A, "alias rd32");
    doRead (0, 10'd800, 1, 32'h5A5A5A5A, "alias rd800");
`endif

    // Five wait states: asynchronous reset in the middle of a read.
    doWrite(3, 10'd5, 32'hCAFEF00D, 4'hF, 6, "w5 wr5");
    doRead (3, 10'd5, 6, 32'hCAFEF00D, "w5 rd5");
    applyStimulus(3, 1'b0, 10'd5, '0, 4'h0);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst async ack", 32'(ack_v[3]), 32'd0);
    checkOutput("rst async err", 32'(err_v[3]), 32'd0);
    checkOutput("rst async dat", dat_v[3], 32'd0);
    #2 rst = 1'b0;
    idleBus();
    tick();
    doRead(3, 10'd5, 6, 32'hCAFEF00D, "post-rst rd5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_ram.md
Name: wb_slave_ram

Overview:
- Wishbone B4 classic responder (slave) fronting an on-chip single-port RAM with byte enables.
- It is the memory-side counterpart of the pipeline's Wishbone bus unit: it accepts CYC/STB/WE, performs a read or a byte-masked write, and returns ACK or ERR.
- Response latency is programmable in wait states, so the bus unit can be exercised against slow memory.

Parameters:
- DEPTH, 768: number of 32-bit words implemented; need not be a power of two.
- ADDR_W, 10: word-address width on the bus.
- WAIT_CYCLES, 0: extra wait states inserted before ACK/ERR. Range 0..15.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; a transfer is requested when cyc&stb.
- wbs_we_i  in  1  1=write, 0=read.
- wbs_adr_i  in  ADDR_W  word address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1.
- wbs_ack_o  out  1  normal termination, registered.
- wbs_err_o  out  1  error termination, registered.

Behaviour:
- Reset:
  - One clock domain; reset is asynchronous, active-high, and asserts immediately.
  - On reset: state=IDLE, wait counter=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0.
  - RAM contents are not reset.
- FSM, one-hot, 3 bits:
  - IDLE=3'b001, WAIT=3'b010, RESP=3'b100.
- IDLE:
  - If cyc&stb is sampled at an edge: latch we, adr, dat, sel and load counter=WAIT_CYCLES.
  - Next state is RESP when WAIT_CYCLES=0, otherwise WAIT.
- WAIT:
  - Counter decrements by 1 each cycle.
  - When counter==1 and cyc is still high, go to RESP on the next edge.
  - If cyc drops at any edge in WAIT, return to IDLE: no write, no ACK/ERR.
- RESP:
  - Exactly one cycle with ack=1 (or err=1); the outputs are registered and rise on the edge that enters RESP.
  - Writes commit to the RAM on the edge entering RESP, for enabled bytes only.
  - Read data is driven on wbs_dat_o in the same cycle as ack.
  - Next state is always IDLE, so ack/err drop after one cycle. There is at least one ack-low cycle between back-to-back transfers, even if stb stays high.
- Latency:
  - Request first visible in cycle 0 → ack in cycle 1+WAIT_CYCLES.
  - Minimum throughput is one transfer per 2+WAIT_CYCLES cycles.
- Request signals:
  - Master changes to adr/dat/sel/we after the request edge are ignored; latched values are used.
  - cyc&stb deasserted in RESP does not cancel the response: ack still pulses once and any write has already committed.
- Read data:
  - wbs_dat_o holds its last value when ack=0.
  - On err, wbs_dat_o is unchanged.
- Simultaneous ack and err never occur.
- sel=4'b0000 write: acked normally, RAM unchanged.

Optional Feature:
- Macro WB_SLAVE_RAM_ERR_EN.
- Defined: latched adr>=DEPTH yields err=1 instead of ack; no write; dat_o unchanged. Wait states are applied as for a normal transfer.
- Undefined: err port is tied 0. Out-of-range addresses alias modulo DEPTH (adr - DEPTH repeatedly folded via comparison; implementation uses adr % DEPTH, synthesized constant) and are acked.

Decomposition:
- Shared package wb_pkg:
  - WB_DAT_W=32 and WB_SEL_W=4.
  - One-hot state localparams WB_ST_IDLE/WB_ST_WAIT/WB_ST_RESP, reusable by bus units.
- Sub-module wb_ram_sp:
  - Synchronous single-port RAM with DEPTH/ADDR_W parameters, 4 byte write enables, registered read.
  - Top-level block holds the FSM, counter, address check and response registers.

Test Plan:
- WAIT_CYCLES=0: write adr=5 dat=32'hDEADBEEF sel=4'hF → ack in cycle 1, one cycle wide. Read adr=5 → ack in cycle 1, dat_o=32'hDEADBEEF.
- WAIT_CYCLES=3: read adr=5 → ack low for cycles 1-3, high in cycle 4 only. stb held high continuously → ack pattern 0,0,0,1,0,0,0,0,1.
- Byte enables: preload 32'h11223344, write 32'hAABBCCDD sel=4'b0101 → read returns 32'h11BB33DD. sel=0 write → ack, data unchanged.
- Abort: WAIT_CYCLES=4, write adr=7 dat=32'h1, drop cyc in cycle 2 → no ack/err. Subsequent read adr=7 returns prior contents.
- WB_SLAVE_RAM_ERR_EN defined: read adr=800 (DEPTH=768) → err=1 one cycle, ack=0, dat_o unchanged. Write adr=800 → err, RAM unmodified.
- Reset mid-op: WAIT_CYCLES=5, assert rst_i asynchronously in cycle 3 → ack/err/dat_o go to 0 immediately. After release, FSM is in IDLE and a new read completes normally.
